// File: rtl/clib_pkg.sv
// Shared helpers for the c_* library: iterator FSM state and a ceil-log2
// used to size index ports.
package clib;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } iter_state_t;

  function automatic int clogb(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/c_lod_iter_lod.sv
// Leading-one detector: keeps only the lowest-index set bit of i_data
// (index 0 is the leading position).
module c_lod #(
  parameter int width = 32
) (
  input  logic [0:width-1] i_data,
  output logic [0:width-1] o_onehot
);

  logic w_found;

  always_comb begin
    w_found  = 1'b0;
    o_onehot = '0;
    for (int i = 0; i < width; i++) begin
      if (i_data[i] && !w_found) begin
        o_onehot[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/c_lod_iter.sv
// Iterates over the set bits of an accepted vector, one one-hot beat per
// set bit, lowest or highest index first depending on dir.
module c_lod_iter
  import clib::*;
#(
  parameter int width = 32,
  parameter int dir   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:width-1]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:width-1]        out_onehot,
  output logic [clogb(width)-1:0] out_index,
  output logic                    out_last,
  output logic                    out_empty
);

  localparam int IW = clogb(width);

  iter_state_t      r_state;
  logic [0:width-1] r_resid;
  logic             r_empty;

  logic [0:width-1] w_lod_in, w_lod_out, w_lead;
  logic [IW-1:0]    w_idx;
  logic             w_valid, w_single, w_last, w_take;

  // dir=1 finds the highest index by mirroring around the same detector.
  if (dir != 0) begin : g_rev
    for (genvar g = 0; g < width; g++) begin : g_bit
      assign w_lod_in[g] = r_resid[width-1-g];
      assign w_lead[g]   = w_lod_out[width-1-g];
    end
  end else begin : g_fwd
    assign w_lod_in = r_resid;
    assign w_lead   = w_lod_out;
  end

  c_lod #(.width(width)) u_lod (
    .i_data  (w_lod_in),
    .o_onehot(w_lod_out)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < width; i++) begin
      if (w_lead[i]) w_idx = w_idx | IW'(i);
    end
  end

  assign w_valid  = (r_state == ITER);
  assign w_single = (|r_resid) && ((r_resid & ~w_lead) == '0);
  // An all-zero vector still produces one (empty) beat, which is also last.
  assign w_last   = w_valid && (r_empty || w_single);
  assign w_take   = in_valid && in_ready;

  assign in_ready   = reset && ((r_state == IDLE) || (out_ready && w_last));
  assign out_valid  = w_valid;
  assign out_onehot = w_valid ? w_lead : '0;
  assign out_index  = w_valid ? w_idx : '0;
  assign out_last   = w_last;
  assign out_empty  = w_valid && r_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_resid <= '0;
      r_empty <= 1'b0;
    end else if (w_take) begin
      r_state <= ITER;
      r_resid <= in_data;
      r_empty <= ~|in_data;
    end else if (w_valid && out_ready) begin
      if (w_last) begin
        r_state <= IDLE;
        r_resid <= '0;
        r_empty <= 1'b0;
      end else begin
        r_resid <= r_resid & ~w_lead;
      end
    end
  end

endmodule

// File: tb/tb_c_lod_iter.sv
// Scoreboard bench: both dir settings run side by side on the same stimulus.
module tb_c_lod_iter;

  typedef struct packed {
    logic [0:7] oh;
    logic [2:0] idx;
    logic       last;
    logic       empty;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [0:7] in_data = '0;
  logic       out_ready = 1'b1;

  logic       rdy0, rdy1, ov0, ov1, last0, last1, emp0, emp1;
  logic [0:7] oh0, oh1;
  logic [2:0] idx0, idx1;

  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;
  bit  rnd_ready = 1'b0;
  beat_t q0[$];
  beat_t q1[$];

  c_lod_iter #(.width(8), .dir(0)) u_d0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
    .out_onehot(oh0), .out_index(idx0), .out_last(last0), .out_empty(emp0)
  );

  c_lod_iter #(.width(8), .dir(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .out_onehot(oh1), .out_index(idx1), .out_last(last1), .out_empty(emp1)
  );

  always #5 clk = ~clk;

  // Reference: walk the vector in emission order and list the set bits.
  task automatic push_model(input logic [0:7] v, input int d);
    int    n, cnt, i;
    beat_t b;
    n = 0;
    for (int k = 0; k < 8; k++) n += int'(v[k]);
    if (n == 0) begin
      b = '{oh: '0, idx: 3'd0, last: 1'b1, empty: 1'b1};
      if (d == 0) q0.push_back(b); else q1.push_back(b);
    end else begin
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
        i = (d == 0) ? k : 7 - k;
        if (v[i]) begin
          cnt++;
          b       = '0;
          b.oh[i] = 1'b1;
          b.idx   = 3'(i);
          b.last  = (cnt == n);
          if (d == 0) q0.push_back(b); else q1.push_back(b);
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic ov, input beat_t got,
                     input logic rdy, input bit have, input beat_t exp);
    logic exp_rdy;
    checks++;
    if (ov) begin
      if (!have) begin
        errors++;
        $display("FAIL %s unexpected beat: got oh=%b idx=%0d last=%b empty=%b, expected no beat",
                 nm, got.oh, got.idx, got.last, got.empty);
      end else if (got !== exp) begin
        errors++;
        $display("FAIL %s beat: got oh=%b idx=%0d last=%b empty=%b, expected oh=%b idx=%0d last=%b empty=%b",
                 nm, got.oh, got.idx, got.last, got.empty, exp.oh, exp.idx, exp.last, exp.empty);
      end
    end else begin
      if (got !== '0) begin
        errors++;
        $display("FAIL %s idle outputs: got oh=%b idx=%0d last=%b empty=%b, expected all zero",
                 nm, got.oh, got.idx, got.last, got.empty);
      end
      checks++;
      if (reset && have) begin
        errors++;
        $display("FAIL %s bubble: got out_valid=0, expected a pending beat idx=%0d", nm, exp.idx);
      end
    end
    exp_rdy = reset && (!ov || (out_ready && have && exp.last));
    checks++;
    if (rdy !== exp_rdy) begin
      errors++;
      $display("FAIL %s in_ready: got %b, expected %b", nm, rdy, exp_rdy);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("dir0", ov0, '{oh0, idx0, last0, emp0}, rdy0, q0.size() != 0,
          (q0.size() != 0) ? q0[0] : beat_t'('0));
      chk("dir1", ov1, '{oh1, idx1, last1, emp1}, rdy1, q1.size() != 0,
          (q1.size() != 0) ? q1[0] : beat_t'('0));
      if (!reset) begin
        q0.delete();
        q1.delete();
      end else begin
        if (ov0 && out_ready && q0.size() != 0) void'(q0.pop_front());
        if (ov1 && out_ready && q1.size() != 0) void'(q1.pop_front());
        if (in_valid && rdy0) push_model(in_data, 0);
        if (in_valid && rdy1) push_model(in_data, 1);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic offer(input logic [0:7] v);
    bit ok;
    in_valid = 1'b1;
    in_data  = v;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = rdy0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL accept timeout: got no in_ready, expected acceptance of %b", v);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain timeout: got %0d/%0d beats pending, expected 0", q0.size(), q1.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:7] v;
    #1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    offer(8'b00100101);
    drain();

    offer(8'b00000000);
    drain();

    // Stall while the middle beat is presented.
    offer(8'b00100101);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Back-to-back vectors: second one rides on the last-beat handshake.
    offer(8'b00100101);
    offer(8'b10000000);
    drain();

    // Reset in the middle of a vector abandons the remaining beats.
    offer(8'b00100101);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    rnd_ready = 1'b1;
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 5))
        0:       v = '0;
        1:       v = 8'(1 << $urandom_range(0, 7));
        2:       v = 8'hFF;
        default: v = 8'($urandom);
      endcase
      offer(v);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #0;
    end
    drain();
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
